// File: rtl/mac_arb.sv
// mac_arb: two-requester round-robin arbiter in front of a shared
// multiply-accumulate unit. A granted requester streams `len` operand pairs;
// each accepted pair adds bits [15:6] of x1*x2 to a 10-bit accumulator. The
// finished sum is presented on res/res_vld until the requester acknowledges.
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   req[1:0]                  job request per requester
//   len0, len1                job length in operand pairs (0 legal)
//   x1_0, x2_0, x1_1, x2_1    unsigned operand pair per requester
//   vld[1:0] / rdy[1:0]       operand pair handshake per requester
//   gnt[1:0]                  one-hot grant
//   res[9:0], res_vld[1:0]    finished result and its per-requester valid
//   res_ack[1:0]              result consumed, per requester
//   ovf                       saturation occurred in the current job
//   busy                      FSM not idle
//
// Configuration: define MAC_ARB_SAT_EN to saturate the accumulator at 1023
// and report ovf; otherwise the accumulator wraps and ovf stays 0.
module mac_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [7:0] x1_0,
  input  logic [7:0] x2_0,
  input  logic [7:0] x1_1,
  input  logic [7:0] x2_1,
  input  logic [1:0] vld,
  output logic [1:0] rdy,
  output logic [1:0] gnt,
  output logic [9:0] res,
  output logic [1:0] res_vld,
  input  logic [1:0] res_ack,
  output logic       ovf,
  output logic       busy
);

  localparam int unsigned LenW  = 4;
  localparam int unsigned OpW   = 8;
  localparam int unsigned AccW  = 10;
  localparam int unsigned ProdW = 16;
  localparam int unsigned MShft = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      rdy_q, rdy_d;
  logic [1:0]      res_vld_q, res_vld_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] res_q, res_d;
  logic [LenW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            last_q, last_d;

  logic [OpW-1:0]  x1_sel, x2_sel;
  logic [AccW-1:0] m;
  logic [AccW:0]   sum;
  logic            accept;

  // Operand mux follows the current grant; scaled product keeps bits [15:6].
  assign x1_sel = gnt_q[1] ? x1_1 : x1_0;
  assign x2_sel = gnt_q[1] ? x2_1 : x2_0;
  assign m      = AccW'((ProdW'(x1_sel) * ProdW'(x2_sel)) >> MShft);
  assign sum    = (AccW+1)'(acc_q) + (AccW+1)'(m);
  assign accept = (state_q == RUN) && ((vld & gnt_q) != 2'b00);

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rdy_q     <= '0;
      res_vld_q <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rdy_q     <= rdy_d;
      res_vld_q <= res_vld_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic; registered outputs are decoded from the next state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie, serve whoever did not go last.
          if (req == 2'b11) gnt_d = last_q ? 2'b01 : 2'b10;
          else              gnt_d = req;
          cnt_d   = gnt_d[1] ? len1 : len0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (cnt_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
`ifdef MAC_ARB_SAT_EN
          if (sum[AccW]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[AccW-1:0];
          end
`else
          acc_d = sum[AccW-1:0];
`endif
          cnt_d = cnt_q - LenW'(1);
          if (cnt_q == LenW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if ((res_ack & gnt_q) != 2'b00) begin
          last_d  = gnt_q[1];
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d     = (state_d == RUN)  ? gnt_d : 2'b00;
    res_vld_d = (state_d == DONE) ? gnt_d : 2'b00;
    res_d     = (state_d == DONE) ? acc_d : '0;
    busy_d    = (state_d != IDLE);
  end

  assign gnt     = gnt_q;
  assign rdy     = rdy_q;
  assign res_vld = res_vld_q;
  assign res     = res_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;

endmodule

// File: doc/mac_arb.md
MAC_ARB -- requirements
Module: mac_arb

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req  in  2  per-requester job request, bit i = requester i.
REQ-004 SHALL have ports: len0, len1  in  4 each  job length in operand pairs; 0 is legal.
REQ-005 SHALL have ports: x1_0, x2_0, x1_1, x2_1  in  8 each  unsigned operand pair per requester.
REQ-006 SHALL have ports: vld  in  2  operand pair valid, per requester.
REQ-007 SHALL have ports: rdy  out  2  operand pair accepted, per requester.
REQ-008 SHALL have ports: gnt  out  2  one-hot grant, registered.
REQ-009 SHALL have ports: res  out  10  accumulated result of the finished job.
REQ-010 SHALL have ports: res_vld  out  2  result valid toward requester i.
REQ-011 SHALL have ports: res_ack  in  2  result consumed by requester i.
REQ-012 SHALL have ports: ovf  out  1  saturation occurred in the current job.
REQ-013 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE with any req bit set SHALL register gnt, load count from the granted len, clear acc and ovf, and go to RUN; gnt is visible the cycle after req is sampled.
REQ-016 Arbitration SHALL be round-robin: with both req set, grant the requester other than last_served; last_served resets to 1, so requester 0 wins the first tie.
REQ-017 A grant with len==0 SHALL go directly to DONE with res=0 and no operand accepted.
REQ-018 In RUN, rdy SHALL equal gnt; rdy for the non-granted requester SHALL be 0.
REQ-019 A pair is accepted on a cycle where vld[g] and rdy[g] are both high.
REQ-020 Per accepted pair: m = bits [15:6] of the 16-bit product x1_g*x2_g; acc <= acc + m; count decrements.
REQ-021 Acceptance with count==1 SHALL move the FSM to DONE; the final sum is in acc at DONE entry.
REQ-022 In RUN, vld low SHALL stall the job with no timeout.
REQ-023 In DONE, res SHALL equal acc and res_vld[g] SHALL be high; both hold until res_ack[g].
REQ-024 res_ack[g] in DONE SHALL clear gnt and res_vld, set last_served=g, and go to IDLE; IDLE lasts at least one cycle before the next grant.
REQ-025 Deasserting req during RUN or DONE SHALL be ignored; the job completes.
REQ-026 res_ack for a non-granted requester, or res_ack outside DONE, SHALL be ignored.
REQ-027 res SHALL be 0 outside DONE.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, gnt=0, rdy=0, res_vld=0, res=0, acc=0, count=0, ovf=0, busy=0, last_served=1.
REQ-029 reset_n asserted mid-job SHALL abort the job with no result delivered; release SHALL be synchronous to clk.

Configuration
REQ-030 With macro MAC_ARB_SAT_EN defined, acc + m exceeding 1023 SHALL clamp acc to 1023 and set ovf, which stays set until the next grant.
REQ-031 Without MAC_ARB_SAT_EN, acc SHALL wrap modulo 1024 and ovf SHALL be tied to 0.

Verification
REQ-032 The bench SHALL cover: req=01, len0=3, pairs (255,255),(128,2),(64,64) -> res=1016+4+64 wrap -> 60 (no macro) or 1023 with ovf=1 (macro), res_vld=01.
REQ-033 The bench SHALL cover: req=11 from reset -> gnt=01 first; after ack with req held at 11 -> gnt=10 next; after that ack -> gnt=01.
REQ-034 The bench SHALL cover: len1=0, req=10 -> DONE one cycle after grant, res=0, rdy never high.
REQ-035 The bench SHALL cover: RUN with vld low for 5 cycles between pairs -> acc and count unchanged across the stall; final res matches the no-stall result.
REQ-036 The bench SHALL cover: reset_n pulsed low mid-RUN -> all outputs 0 immediately; next req=01 with len0=1, pair (16,16) -> res=4.
REQ-037 The bench SHALL cover: res_ack held off 10 cycles in DONE -> res and res_vld stable; res_ack on the wrong bit is ignored.
